// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode-side bus of the program-counter unit.
// master drives op/control/table writes, slave returns pc and status.
interface pc_sequencer_if #(
   parameter int D     = 12,
   parameter int SW    = 4,
   parameter int IMM_W = 4
);
   logic             start;
   logic             stall;
   logic [2:0]       op;
   logic             cond;
   logic [SW-1:0]    sel;
   logic [IMM_W-1:0] imm;
   logic             lut_we;
   logic [SW-1:0]    lut_waddr;
   logic [D-1:0]     lut_wdata;
   logic [D-1:0]     pc;
   logic             running;
   logic             done;
   logic             stack_ovf;
   logic             stack_udf;

   modport master (
      output start, stall, op, cond, sel, imm,
      output lut_we, lut_waddr, lut_wdata,
      input  pc, running, done, stack_ovf, stack_udf
   );

   modport slave (
      input  start, stall, op, cond, sel, imm,
      input  lut_we, lut_waddr, lut_wdata,
      output pc, running, done, stack_ovf, stack_udf
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with signed jump table, relative/table/
// absolute branches, run/done FSM and a return-address stack.
// Ports: Clk; Reset (sync, active-low); bus (pc_sequencer_if.slave):
//   in  start stall op cond sel imm lut_we lut_waddr lut_wdata
//   out pc running done stack_ovf stack_udf
// Macro PC_RAS_EN builds the stack; without it CALL is a relative
// jump, RET is SEQ and both stack flags read 0.
module pc_sequencer #(
   parameter int D           = 12,
   parameter int LUT_ENTRIES = 16,
   parameter int IMM_W       = 4,
   parameter int STACK_DEPTH = 4
) (
   input logic           Clk,
   input logic           Reset,
   pc_sequencer_if.slave bus
);
   localparam int SW = $clog2(LUT_ENTRIES);

   localparam logic [2:0] OP_SEQ  = 3'b000;
   localparam logic [2:0] OP_BRI  = 3'b001;
   localparam logic [2:0] OP_BRL  = 3'b010;
   localparam logic [2:0] OP_JMPA = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;

   localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

   if (STACK_DEPTH < 1) begin : g_depth_chk
      $error("pc_sequencer: STACK_DEPTH must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q;
   logic [D-1:0] pc_q;
   logic         running_q;
   logic         done_q;
   logic [D-1:0] lut [LUT_ENTRIES];

   logic [SW-1:0] rd_idx;
   logic [D-1:0]  lut_rd;
   logic [D-1:0]  pc_inc;
   logic [D-1:0]  imm_ext;
   logic [D-1:0]  pc_nxt;

   // Read sees the array before this edge's write: same-index
   // write/read returns the old entry.
   assign rd_idx  = bus.sel;
   assign lut_rd  = lut[rd_idx];
   assign pc_inc  = pc_q + ONE;
   assign imm_ext = {{(D-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};

`ifdef PC_RAS_EN
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [D-1:0]   stk [STACK_DEPTH];
   logic [SPW-1:0] sp_q;
   logic           ovf_q;
   logic           udf_q;
   logic           stk_full;
   logic           stk_empty;
   logic [SIW-1:0] push_idx;
   logic [SIW-1:0] pop_idx;

   assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
   assign stk_empty = (sp_q == '0);
   assign push_idx  = SIW'(sp_q);
   assign pop_idx   = SIW'(sp_q - 1'b1);
`endif

   always_comb begin
      pc_nxt = pc_inc;
      case (bus.op)
         OP_BRI:  if (bus.cond) pc_nxt = pc_q + imm_ext;
         OP_BRL:  if (bus.cond) pc_nxt = pc_q + lut_rd;
         OP_JMPA: pc_nxt = lut_rd;
         OP_CALL: pc_nxt = pc_q + lut_rd;
`ifdef PC_RAS_EN
         // Underflowing RET falls through to pc+1.
         OP_RET:  if (!stk_empty) pc_nxt = stk[pop_idx];
`endif
         OP_HALT: pc_nxt = pc_q;
         default: pc_nxt = pc_inc;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < LUT_ENTRIES; i++) lut[i] <= '0;
`ifdef PC_RAS_EN
         sp_q  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
`endif
      end else begin
         // Table writes land in every state, stall included.
         if (bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (!bus.stall) begin
                  pc_q <= pc_nxt;
                  if (bus.op == OP_HALT) begin
                     state_q   <= DONE;
                     running_q <= 1'b0;
                     done_q    <= 1'b1;
                  end
`ifdef PC_RAS_EN
                  // Overflowing CALL still jumps; only the push is lost.
                  if (bus.op == OP_CALL) begin
                     if (stk_full) begin
                        ovf_q <= 1'b1;
                     end else begin
                        stk[push_idx] <= pc_inc;
                        sp_q          <= sp_q + 1'b1;
                     end
                  end
                  if (bus.op == OP_RET) begin
                     if (stk_empty) udf_q <= 1'b1;
                     else           sp_q  <= sp_q - 1'b1;
                  end
`endif
               end
            end
            DONE: begin
               if (bus.start) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
                  done_q    <= 1'b0;
                  pc_q      <= '0;
`ifdef PC_RAS_EN
                  sp_q  <= '0;
                  ovf_q <= 1'b0;
                  udf_q <= 1'b0;
`endif
               end
            end
            default: begin
               state_q   <= IDLE;
               running_q <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc      = pc_q;
   assign bus.running = running_q;
   assign bus.done    = done_q;
`ifdef PC_RAS_EN
   assign bus.stack_ovf = ovf_q;
   assign bus.stack_udf = udf_q;
`else
   assign bus.stack_ovf = 1'b0;
   assign bus.stack_udf = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer, default build or
// with PC_RAS_EN defined (stack scenarios adapt to the macro).
module tb_pc_sequencer;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   localparam logic [2:0] SEQ  = 3'b000;
   localparam logic [2:0] BRI  = 3'b001;
   localparam logic [2:0] BRL  = 3'b010;
   localparam logic [2:0] JMPA = 3'b011;
   localparam logic [2:0] CALL = 3'b100;
   localparam logic [2:0] RET  = 3'b101;
   localparam logic [2:0] HALT = 3'b110;
   localparam logic [2:0] RSV  = 3'b111;

   pc_sequencer_if #(.D(12), .SW(4), .IMM_W(4)) bus ();

   pc_sequencer #(
      .D(12), .LUT_ENTRIES(16), .IMM_W(4), .STACK_DEPTH(4)
   ) dut (
      .Clk(clk),
      .Reset(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at the negedge; outputs are read at the next negedge.
   task automatic tick();
      @(negedge clk);
      bus.lut_we = 1'b0;
      bus.start  = 1'b0;
   endtask

   task automatic drv(input logic [2:0] o, input logic [3:0] s,
                      input logic c, input logic [3:0] i);
      bus.op   = o;
      bus.sel  = s;
      bus.cond = c;
      bus.imm  = i;
   endtask

   task automatic wr(input logic [3:0] a, input logic [11:0] d);
      bus.lut_we    = 1'b1;
      bus.lut_waddr = a;
      bus.lut_wdata = d;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b1;
      wr(4'd3, 12'h555);
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL rst_pc: got %h want 000", bus.pc); end
      checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_run: got %b want 0", bus.running); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", bus.done); end
      checks++; if ({bus.stack_ovf, bus.stack_udf} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b%b want 00", bus.stack_ovf, bus.stack_udf); end
      rst_n = 1'b1;
      bus.start = 1'b0;
      bus.lut_we = 1'b0;
      tick();
      checks++; if ({bus.running, bus.pc} !== {1'b0, 12'h000}) begin errors++; $display("FAIL idle_hold: run=%b pc=%h want 0/000", bus.running, bus.pc); end
      bus.start = 1'b1;
      tick();
      checks++; if ({bus.running, bus.pc} !== {1'b1, 12'h000}) begin errors++; $display("FAIL idle_start: run=%b pc=%h want 1/000", bus.running, bus.pc); end
      tick();
      checks++; if (bus.pc !== 12'h001) begin errors++; $display("FAIL first_seq: got %h want 001", bus.pc); end
      drv(JMPA, 4'd3, 1'b0, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL rst_lut: got %h want 000", bus.pc); end
   endtask

   task automatic test_seq_halt();
      drv(HALT, 4'd0, 1'b0, 4'd0);
      tick();
      bus.start = 1'b1;
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      tick();
      checks++; if ({bus.running, bus.done, bus.pc} !== {2'b10, 12'h000}) begin errors++; $display("FAIL restart: run=%b done=%b pc=%h", bus.running, bus.done, bus.pc); end
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++; if (bus.pc !== 12'(k)) begin errors++; $display("FAIL seq%0d: got %h want %h", k, bus.pc, 12'(k)); end
      end
      drv(HALT, 4'd0, 1'b0, 4'd0);
      tick();
      checks++; if ({bus.running, bus.done, bus.pc} !== {2'b01, 12'h005}) begin errors++; $display("FAIL halt: run=%b done=%b pc=%h want 0/1/005", bus.running, bus.done, bus.pc); end
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h005) begin errors++; $display("FAIL done_hold: got %h want 005", bus.pc); end
      bus.start = 1'b1;
      tick();
      checks++; if ({bus.running, bus.done, bus.pc} !== {2'b10, 12'h000}) begin errors++; $display("FAIL done_start: run=%b done=%b pc=%h", bus.running, bus.done, bus.pc); end
   endtask

   task automatic test_brl();
      wr(4'd1, 12'h064);
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      tick();
      wr(4'd3, 12'hF9C);
      drv(JMPA, 4'd1, 1'b0, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h064) begin errors++; $display("FAIL jmpa64: got %h want 064", bus.pc); end
      drv(BRL, 4'd3, 1'b1, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL brl_taken: got %h want 000", bus.pc); end
      drv(JMPA, 4'd1, 1'b0, 4'd0);
      tick();
      drv(BRL, 4'd3, 1'b0, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h065) begin errors++; $display("FAIL brl_not: got %h want 065", bus.pc); end
      wr(4'd3, 12'h010);
      drv(BRL, 4'd3, 1'b1, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h001) begin errors++; $display("FAIL brl_old: got %h want 001", bus.pc); end
      tick();
      checks++; if (bus.pc !== 12'h011) begin errors++; $display("FAIL brl_new: got %h want 011", bus.pc); end
   endtask

   task automatic test_wrap();
      wr(4'd2, 12'h002);
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      tick();
      drv(JMPA, 4'd2, 1'b0, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h002) begin errors++; $display("FAIL jmpa2: got %h want 002", bus.pc); end
      drv(BRI, 4'd0, 1'b1, 4'b1100);
      tick();
      checks++; if (bus.pc !== 12'hFFE) begin errors++; $display("FAIL bri_neg: got %h want ffe", bus.pc); end
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      tick();
      tick();
      checks++; if (bus.pc !== 12'h000) begin errors++; $display("FAIL seq_wrap: got %h want 000", bus.pc); end
      drv(BRI, 4'd0, 1'b0, 4'b1100);
      tick();
      checks++; if (bus.pc !== 12'h001) begin errors++; $display("FAIL bri_not: got %h want 001", bus.pc); end
      wr(4'd5, 12'h123);
      drv(BRI, 4'd0, 1'b1, 4'b0111);
      tick();
      checks++; if (bus.pc !== 12'h008) begin errors++; $display("FAIL bri_pos: got %h want 008", bus.pc); end
      drv(JMPA, 4'd5, 1'b0, 4'd0);
      tick();
      checks++; if (bus.pc !== 12'h123) begin errors++; $display("FAIL jmpa5: got %h want 123", bus.pc); end
      wr(4'd6, 12'h010);
      drv(RSV, 4'd5, 1'b1, 4'b0111);
      tick();
      checks++; if (bus.pc !== 12'h124) begin errors++; $display("FAIL rsv_seq: got %h want 124", bus.pc); end
   endtask

   task automatic test_stack();
      logic [11:0] exp_pc;
      exp_pc = 12'h124;
      for (int k = 1; k <= 5; k++) begin
         drv(CALL, 4'd6, 1'b0, 4'd0);
         tick();
         exp_pc = exp_pc + 12'h010;
         checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL call%0d: got %h want %h", k, bus.pc, exp_pc); end
`ifdef PC_RAS_EN
         checks++; if (bus.stack_ovf !== (k == 5)) begin errors++; $display("FAIL ovf%0d: got %b want %b", k, bus.stack_ovf, k == 5); end
`else
         checks++; if (bus.stack_ovf !== 1'b0) begin errors++; $display("FAIL ovf%0d: got %b want 0", k, bus.stack_ovf); end
`endif
      end
      for (int k = 1; k <= 5; k++) begin
         drv(RET, 4'd6, 1'b0, 4'd0);
         tick();
`ifdef PC_RAS_EN
         exp_pc = (k == 5) ? 12'h126 : 12'(12'h165 - 12'h010 * k);
         checks++; if (bus.stack_udf !== (k == 5)) begin errors++; $display("FAIL udf%0d: got %b want %b", k, bus.stack_udf, k == 5); end
`else
         exp_pc = exp_pc + 12'h001;
         checks++; if (bus.stack_udf !== 1'b0) begin errors++; $display("FAIL udf%0d: got %b want 0", k, bus.stack_udf); end
`endif
         checks++; if (bus.pc !== exp_pc) begin errors++; $display("FAIL ret%0d: got %h want %h", k, bus.pc, exp_pc); end
      end
   endtask

   task automatic test_stall();
      logic [11:0] base;
      base = bus.pc;
      bus.stall = 1'b1;
      drv(CALL, 4'd6, 1'b0, 4'd0);
      for (int k = 1; k <= 3; k++) begin
         if (k == 2) wr(4'd6, 12'h020);
         tick();
         checks++; if (bus.pc !== base) begin errors++; $display("FAIL stall%0d: got %h want %h", k, bus.pc, base); end
      end
      bus.stall = 1'b0;
      tick();
      checks++; if (bus.pc !== 12'(base + 12'h020)) begin errors++; $display("FAIL stall_call: got %h want %h", bus.pc, 12'(base + 12'h020)); end
      drv(RET, 4'd0, 1'b0, 4'd0);
      tick();
`ifdef PC_RAS_EN
      checks++; if (bus.pc !== 12'(base + 12'h001)) begin errors++; $display("FAIL stall_ret: got %h want %h", bus.pc, 12'(base + 12'h001)); end
`else
      checks++; if (bus.pc !== 12'(base + 12'h021)) begin errors++; $display("FAIL stall_ret: got %h want %h", bus.pc, 12'(base + 12'h021)); end
`endif
      bus.stall = 1'b1;
      drv(HALT, 4'd0, 1'b0, 4'd0);
      tick();
      checks++; if ({bus.running, bus.done} !== 2'b10) begin errors++; $display("FAIL stall_halt: run=%b done=%b want 1/0", bus.running, bus.done); end
      bus.stall = 1'b0;
      tick();
      checks++; if ({bus.running, bus.done} !== 2'b01) begin errors++; $display("FAIL halt2: run=%b done=%b want 0/1", bus.running, bus.done); end
      bus.start = 1'b1;
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      tick();
      checks++; if ({bus.stack_ovf, bus.stack_udf, bus.pc} !== {2'b00, 12'h000}) begin errors++; $display("FAIL restart_clr: ovf=%b udf=%b pc=%h", bus.stack_ovf, bus.stack_udf, bus.pc); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      bus.lut_we = 1'b0;
      bus.lut_waddr = '0;
      bus.lut_wdata = '0;
      drv(SEQ, 4'd0, 1'b0, 4'd0);
      test_reset();
      test_seq_halt();
      test_brl();
      test_wrap();
      test_stack();
      test_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program-counter unit. Replaces the fixed combinational branch-offset table with a registered PC, a runtime-writable signed jump table, conditional relative, table and absolute branches, a call/return address stack, and a run/done state machine. Sits between instruction decode and instruction ROM address; decode drives op/cond/sel/imm each cycle, and the PC output addresses the ROM.

Parameters:
D, 12, PC and jump-table entry width (bits); all PC arithmetic is modulo 2^D
LUT_ENTRIES, 16, number of jump-table entries; SW = $clog2(LUT_ENTRIES)
IMM_W, 4, width of the signed relative immediate
STACK_DEPTH, 4, return-address stack entries (>=1)

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-low reset, sampled on rising Clk
start  in  1  leave IDLE/DONE and begin execution
stall  in  1  freeze PC and stack this cycle
op  in  3  PC operation (encoding below)
cond  in  1  branch condition for conditional ops (1 = taken)
sel  in  SW  jump-table index
imm  in  IMM_W  signed relative offset
lut_we  in  1  jump-table write enable
lut_waddr  in  SW  jump-table write index
lut_wdata  in  D  signed jump-table write data
pc  out  D  current program counter
running  out  1  high in RUN
done  out  1  high in DONE
stack_ovf  out  1  sticky: push attempted while stack full
stack_udf  out  1  sticky: pop attempted while stack empty

Behaviour:
- Reset: Reset=0 at a rising edge -> pc=0, state IDLE, running=0, done=0, sp=0, stack_ovf=0, stack_udf=0, all jump-table entries=0. Reset wins over every other input.
- States: IDLE -> RUN on start. RUN -> DONE on op=HALT when stall=0. DONE -> RUN on start; this transition forces pc=0, sp=0 and clears both sticky flags. start is ignored in RUN.
- pc is held in IDLE and DONE. In RUN with stall=1, pc, sp and the stack are held.
- RUN, stall=0, one update per cycle. The new pc is visible the cycle after the op is presented (1-cycle latency):
  - 000 SEQ: pc+1
  - 001 BRI: cond ? pc+sext(imm) : pc+1
  - 010 BRL: cond ? pc+lut[sel] : pc+1 (entry treated as a signed D-bit offset)
  - 011 JMPA: pc=lut[sel], unconditional absolute
  - 100 CALL: push pc+1, then pc+lut[sel], unconditional
  - 101 RET: pc=pop
  - 110 HALT: pc held; enter DONE
  - 111: reserved, behaves as SEQ
- Arithmetic: D-bit wrap-around with no saturation. Example: pc=0xFFF with SEQ -> 0x000. pc=0x002 with BRI imm=4'b1100 (-4) -> 0xFFE.
- Jump table:
  - Read is combinational from the array.
  - Write occurs at the rising edge when lut_we=1, in any state including stall, but not during reset.
  - Same-cycle write and read of the same index: the read returns the old value; the new value is visible from the next cycle.
- Stack:
  - LIFO with sp in 0..STACK_DEPTH.
  - CALL with sp=STACK_DEPTH: push is dropped, stack_ovf<=1, and the jump still occurs.
  - RET with sp=0: stack_udf<=1 and pc<=pc+1.
  - Sticky flags clear only on reset or on DONE->RUN.
- Outputs are registered or direct decodes of registered state; there is no combinational input-to-output path.

Optional Feature:
Macro PC_RAS_EN.
- Defined: the stack, CALL/RET behaviour and the stack_ovf/stack_udf flags operate as above.
- Undefined: no stack storage is built. CALL behaves as an unconditional relative jump, pc+lut[sel], with no push. RET behaves as SEQ. stack_ovf and stack_udf are tied to 0.

Test Plan:
- Reset=0 for 2 cycles with start=1 and lut_we=1 -> pc=0, state IDLE, running=0, done=0, flags 0, table unchanged (all 0).
- start, then 5x SEQ, then HALT -> pc sequence 0,1,2,3,4,5; done=1 the cycle after HALT; pc holds 5; a further start -> pc=0, running=1.
- Write lut[3]=0xF9C (-100) at pc=0x064, then BRL sel=3 cond=1 -> pc=0x000. Same op with cond=0 -> pc=0x065. Write and BRL on the same index in the same cycle -> old entry used.
- BRI imm=-4 at pc=2 -> 0xFFE. SEQ at pc=0xFFF -> 0x000. JMPA with lut[5]=0x123 -> pc=0x123.
- PC_RAS_EN defined, STACK_DEPTH=4: 5 nested CALLs -> stack_ovf=1 after the 5th. 4 RETs return to the correct pc+1 values. A 5th RET -> stack_udf=1, pc+1.
- stall=1 held 3 cycles during a CALL -> pc and sp unchanged, a lut write during the stall takes effect; the CALL executes the cycle stall drops.
